// File: rtl/serial_alu32_if.sv
// Bus between the serial ALU sequencer and the stage that issues operations
// and consumes the published result word and flags.
interface serial_alu32_if #(
  parameter int WIDTH = 32
);
  // start is a request that is taken only while the sequencer is idle and
  // never queued. busy covers the WIDTH bit cycles. done pulses for one cycle
  // as out/flags take a new value. out/flags hold between done pulses.
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carryout;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output start, A, B, control,
    input  busy, done, out, carryout, zero, negative, overflow
  );

  modport slave (
    input  start, A, B, control,
    output busy, done, out, carryout, zero, negative, overflow
  );
endinterface

// File: rtl/serial_alu32.sv
// Bit-serial word ALU: one alu1 slice processes a bit pair per cycle, LSB
// first, with the inter-bit carry held in a flop.
module alu1 (
  input  logic       a,
  input  logic       b,
  input  logic       carryin,
  input  logic [2:0] control,
  output logic       out,
  output logic       carryout
);
  logic b_eff;

  // Odd arithmetic codes subtract by inverting B; carry-in supplies the +1.
  assign b_eff = b ^ (control[0] & ~control[2]);

  always_comb begin
    out      = a ^ b_eff ^ carryin;
    carryout = (a & b_eff) | (a & carryin) | (b_eff & carryin);
    case (control)
      3'd4:    out = a & b;
      3'd5:    out = a | b;
      3'd6:    out = ~(a | b);
      3'd7:    out = a ^ b;
      default: out = a ^ b_eff ^ carryin;
    endcase
  end
endmodule

module serial_alu32 #(
  parameter int WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  serial_alu32_if.slave   bus,
  output logic [1:0]      dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       ctl_q;
  logic             carry_q;
  logic             bit_out;
  logic             bit_cout;
  logic             last_bit;
  logic [WIDTH-1:0] result_full;

  alu1 u_slice (
    .a        (a_q[count]),
    .b        (b_q[count]),
    .carryin  (carry_q),
    .control  (ctl_q),
    .out      (bit_out),
    .carryout (bit_cout)
  );

  assign last_bit    = (count == CW'(WIDTH - 1));
  // Result bits enter at the MSB end, so after WIDTH shifts bit 0 sits at bit 0.
  assign result_full = {bit_out, res_q[WIDTH-1:1]};

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last_bit)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      count        <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      ctl_q        <= 3'd0;
      bus.out      <= '0;
      bus.carryout <= 1'b0;
      bus.zero     <= 1'b0;
      bus.negative <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            ctl_q   <= bus.control;
            carry_q <= bus.control[0] & ~bus.control[2];
            count   <= '0;
          end
        end
        RUN: begin
          res_q   <= result_full;
          carry_q <= bit_cout;
          if (last_bit) begin
            bus.out      <= result_full;
            bus.zero     <= (result_full == '0);
            bus.negative <= bit_out;
            // Signed overflow: carry into the MSB differs from carry out of it.
            bus.carryout <= ~ctl_q[2] & bit_cout;
            bus.overflow <= ~ctl_q[2] & (carry_q ^ bit_cout);
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu32.sv
// Self-checking bench for serial_alu32 at WIDTH=32 and WIDTH=8, checked
// against a word-level arithmetic reference model.
module tb_serial_alu32;
  localparam int W  = 32;
  localparam int W8 = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state8;

  serial_alu32_if #(.WIDTH(W))  bus ();
  serial_alu32_if #(.WIDTH(W8)) bus8 ();

  serial_alu32 #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  serial_alu32 #(.WIDTH(W8)) dut8 (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus8),
    .dbg_state (dbg_state8)
  );

  // clock / reset
  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [33:0] exp_q[$];  // {carryout, overflow, result}
  logic [31:0] last_pub;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word-level reference: plain arithmetic on w-bit values.
  function automatic logic [33:0] ref_alu(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic [2:0] c);
    longint unsigned mask, aa, bb, full;
    logic [31:0] r;
    logic co, ov, sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    aa   = 64'(a) & mask;
    bb   = 64'(b) & mask;
    co   = 1'b0;
    ov   = 1'b0;
    case (c)
      3'd0, 3'd2: full = aa + bb;
      3'd1, 3'd3: full = aa + (~bb & mask) + 64'd1;
      3'd4:       full = aa & bb;
      3'd5:       full = aa | bb;
      3'd6:       full = ~(aa | bb) & mask;
      default:    full = aa ^ bb;
    endcase
    r = 32'(full & mask);
    if (c[2] == 1'b0) begin
      co = ((full >> w) & 64'd1) != 64'd0;
      sa = a[w-1];
      sb = b[w-1];
      sr = r[w-1];
      ov = c[0] ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    end
    return {co, ov, r};
  endfunction

  task automatic check_result(input logic [33:0] e);
    check_eq("out",      bus.out,                e[31:0]);
    check_eq("carryout", 32'(bus.carryout),      32'(e[33]));
    check_eq("overflow", 32'(bus.overflow),      32'(e[32]));
    check_eq("zero",     32'(bus.zero),          32'(e[31:0] == 32'd0));
    check_eq("negative", 32'(bus.negative),      32'(e[31]));
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_busy"},  32'(bus.busy), 32'd0);
    check_eq({tag, "_done"},  32'(bus.done), 32'd0);
    check_eq({tag, "_out"},   bus.out, 32'd0);
    check_eq({tag, "_flags"}, 32'({bus.carryout, bus.zero, bus.negative, bus.overflow}), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus8.start = 1'b0;
    @(posedge clock); #1;
    reset    = 1'b0;
    last_pub = 32'd0;
  endtask

  // driver: issue one op on the 32-bit unit and follow it to IDLE
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input bit hold);
    int busy_cycles, done_cycles, done_k, overlap, moved;
    logic [33:0] e;
    busy_cycles = 0; done_cycles = 0; done_k = -1; overlap = 0; moved = 0;
    exp_q.push_back(ref_alu(W, a, b, c));
    bus.A = a; bus.B = b; bus.control = c; bus.start = 1'b1;
    for (int k = 0; k <= W + 1; k++) begin
      @(posedge clock); #1;
      if (!hold) bus.start = 1'b0;
      else begin
        bus.A = $urandom;
        bus.B = $urandom;
      end
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_cycles++;
        if (done_k < 0) done_k = k;
      end
      if (bus.busy && bus.done) overlap++;
      if (k < W && bus.out !== last_pub) moved++;
      if (k == W) begin
        e = exp_q.pop_front();
        check_result(e);
        last_pub = e[31:0];
      end
    end
    check_eq("busy_cycles", 32'(busy_cycles), 32'(W));
    check_eq("done_pulses", 32'(done_cycles), 32'd1);
    check_eq("done_latency", 32'(done_k), 32'(W));
    check_eq("busy_done_overlap", 32'(overlap), 32'd0);
    check_eq("out_moved_in_run", 32'(moved), 32'd0);
    if (hold) begin
      @(posedge clock); #1;
      check_eq("reaccept_busy", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
    int done_k;
    logic [33:0] e;
    done_k = -1;
    e = ref_alu(W8, 32'(a), 32'(b), c);
    bus8.A = a; bus8.B = b; bus8.control = c; bus8.start = 1'b1;
    for (int k = 0; k <= W8 + 1; k++) begin
      @(posedge clock); #1;
      bus8.start = 1'b0;
      if (bus8.done && done_k < 0) done_k = k;
      if (k == W8) begin
        check_eq("out8",      32'(bus8.out),      e[31:0]);
        check_eq("carryout8", 32'(bus8.carryout), 32'(e[33]));
        check_eq("overflow8", 32'(bus8.overflow), 32'(e[32]));
        check_eq("zero8",     32'(bus8.zero),     32'(e[31:0] == 32'd0));
        check_eq("negative8", 32'(bus8.negative), 32'(e[7]));
      end
    end
    check_eq("done_latency8", 32'(done_k), 32'(W8));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    reset = 1'b1;
    bus.start = 1'b0;  bus.A = '0;  bus.B = '0;  bus.control = 3'd0;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.control = 3'd0;
    last_pub = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_cleared("reset");
    check_eq("reset_state8", 32'(dbg_state8), 32'd0);

    // directed cases
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 3'd2, 1'b0);
    run_op(32'd5, 32'd5, 3'd3, 1'b0);
    run_op(32'd0, 32'd1, 3'd3, 1'b0);
    run_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd6, 1'b0);
    run_op(32'hFFFF_0000, 32'h00FF_FF00, 3'd7, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 3'd0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 3'd1, 1'b0);

    // random ops with random idle gaps
    for (int i = 0; i < 24; i++) begin
      run_op($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end

    // reset in the middle of an operation
    run_op(32'd1, 32'd1, 3'd2, 1'b0);
    bus.A = $urandom; bus.B = $urandom; bus.control = 3'd2; bus.start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clock); #1;
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    last_pub = 32'd0;
    check_cleared("midrun_reset");
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (bus.done) done_seen++;
    end
    check_eq("no_done_after_abort", 32'(done_seen), 32'd0);
    run_op(32'd3, 32'd4, 3'd2, 1'b0);

    // start held and operands scrambled after accept
    run_op(32'h1234_5678, 32'h0FED_CBA9, 3'd3, 1'b1);
    do_reset();
    check_cleared("post_hold_reset");

    // reset and start at the same edge
    bus.A = 32'd9; bus.B = 32'd9; bus.control = 3'd2; bus.start = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    check_eq("rst_start_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_start_state", 32'(dbg_state), 32'd0);
    reset = 1'b0; bus.start = 1'b0;
    @(posedge clock); #1;
    check_eq("rst_start_busy_next", 32'(bus.busy), 32'd0);
    check_eq("rst_start_state_next", 32'(dbg_state), 32'd0);

    // narrow instance
    run_op8(8'hFF, 8'h01, 3'd2);
    run_op8(8'h7F, 8'h01, 3'd2);
    for (int i = 0; i < 6; i++)
      run_op8(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_alu32.md
# serial_alu32

Bit-serial word ALU sequencer feeding a single instance of the team's 1-bit ALU slice `alu1`. It latches two WIDTH-bit operands and a 3-bit ALU control code on a start pulse, then drives one bit pair per cycle into the slice, LSB first. It holds the inter-bit carry in a flop and shifts the slice output into a result register. On completion it publishes the result word plus carryout, zero, negative and overflow flags to the downstream register-file/flags stage.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥2)

Ports:
- clock  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high; the only reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  operand A; latched on accepted start
- B  input  WIDTH  operand B; latched on accepted start
- control  input  3  ALU code; latched on accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse when a new result is published
- out  output  WIDTH  last published result
- carryout  output  1  final carry of last arithmetic op; 0 after logic op
- zero  output  1  last published result == 0
- negative  output  1  last published result MSB
- overflow  output  1  signed overflow of last arithmetic op; 0 after logic op

## Operation
- Control codes are 2=ADD, 3=SUB, 4=AND, 5=OR, 6=NOR, 7=XOR. Codes 0 and 1 pass to the slice unchanged: 0 behaves as ADD, 1 as SUB.
- Datapath is exactly one `alu1` slice. Its inputs are latched A[i], latched B[i], carry flop and latched control. B inversion for SUB happens inside the slice.
- Carry flop initial value on accept = control[0] if control[2]==0, else 0.
- FSM states:
  - IDLE: start=1 → latch A, B, control; init carry; count=0; go to RUN. start=0 → stay.
  - RUN: each cycle, apply bit `count` to the slice. Shift the slice `out` into the result shift register from the MSB end. Carry flop ← slice carryout; count++. On the cycle processing bit WIDTH-1, publish and go to DONE.
  - DONE: done=1 for this cycle only; unconditionally go to IDLE.
- Publish (same edge as bit WIDTH-1 is processed):
  - out ← full result.
  - zero ← (result==0).
  - negative ← result[WIDTH-1].
  - For arithmetic codes (control[2]==0): carryout ← slice carryout at bit WIDTH-1; overflow ← carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - For logic codes: carryout ← 0 and overflow ← 0.
- out and flags are stable outside publish edges; they do not change during RUN.
- start while in RUN or DONE is ignored, not queued. Input changes after acceptance have no effect.
- count is ceil(log2(WIDTH)) bits and never wraps inside an operation; it is reset to 0 on each accept.

## Timing
- Reset (synchronous, at any edge with reset=1) forces the following, overriding all other behaviour including start at the same edge:
  - state=IDLE, count=0, carry=0
  - busy=0, done=0
  - out=0, carryout=0, zero=0, negative=0, overflow=0
- Reset mid-RUN abandons the operation: no done pulse, no publish.
- start sampled high at edge E in IDLE:
  - busy=1 for cycles after edges E..E+WIDTH-1, i.e. WIDTH cycles.
  - Results are valid and done=1 in the cycle after edge E+WIDTH.
  - IDLE is re-entered after edge E+WIDTH+1.
- Earliest next accept is edge E+WIDTH+2, giving back-to-back throughput of one op per WIDTH+2 cycles.
- busy and done are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Case 1, ADD overflow: ADD, A=0x7FFFFFFF, B=0x00000001 → out=0x80000000, overflow=1, negative=1, zero=0, carryout=0. done at edge E+33, busy high exactly 32 cycles.
- Case 2, SUB equal and SUB borrow:
  - SUB, A=5, B=5 → out=0, zero=1, carryout=1, overflow=0.
  - Then SUB, A=0, B=1 → out=0xFFFFFFFF, negative=1, carryout=0, overflow=0.
- Case 3, logic ops:
  - NOR, A=0xF0F0F0F0, B=0x0F0F0F0F → out=0, zero=1, overflow=0, carryout=0.
  - XOR, A=0xFFFF0000, B=0x00FFFF00 → out=0xFF00FF00, negative=1.
- Case 4, ignored start and held operands: start held high through RUN and DONE while A and B change every cycle after accept.
  - Result equals the op on the latched values; exactly one done pulse.
  - The next accept occurs at E+34, not earlier.
- Case 5, reset mid-operation: reset pulsed when count=10 → next cycle busy=0, out=0, all flags 0, no done ever. A subsequent ADD 3+4 gives out=7 after 33 cycles.
- Case 6, reset with start: reset and start both high at the same edge → remains IDLE, busy=0. Also check WIDTH=8 with ADD 0xFF+0x01 → out=0x00, zero=1, carryout=1, done at E+9.
